// File: rtl/random_pick.sv
// ============================================================================
// Module   : random_pick
// Purpose  : Uniform index in [0, bound) via masked rejection sampling, with a
//            bounded-latency fallback and a noise-weighted walk decision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module random_pick #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 8,
  parameter int P_W       = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rnd_in,
  input  logic             req,
  input  logic [IDX_W-1:0] bound,
  input  logic [P_W-1:0]   noise,
  output logic             busy,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic             walk,
  output logic             err
);

  localparam int c_TRY_W = $clog2(MAX_TRIES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_bound;
  logic [IDX_W-1:0]   r_mask;
  logic [P_W-1:0]     r_noise;
  logic [c_TRY_W-1:0] r_tries;
  logic               r_err;
  logic [IDX_W-1:0]   r_index;
  logic               r_walk;

  logic [IDX_W-1:0]   w_bm1;
  logic [IDX_W-1:0]   w_mask;
  logic [IDX_W-1:0]   w_cand;
  logic               w_walk;
  logic               w_zero;
  logic               w_hit;
  logic               w_last;
  logic               w_exit;
  logic               w_unused;

  // Smear the top set bit of (bound-1) downwards: smallest all-ones mask covering bound-1.
  always_comb begin
    w_bm1  = bound - IDX_W'(1);
    w_mask = w_bm1;
    for (int s = 1; s < IDX_W; s = s * 2) begin
      w_mask = w_mask | (w_mask >> s);
    end
    if (bound <= IDX_W'(1)) begin
      w_mask = '0;
    end
  end

  assign w_cand   = rnd_in[IDX_W-1:0] & r_mask;
  assign w_walk   = (rnd_in[WIDTH-1 -: P_W] < r_noise);
  assign w_zero   = (r_bound == '0);
  assign w_hit    = (w_cand < r_bound);
  assign w_last   = (r_tries == c_TRY_W'(MAX_TRIES - 1));
  assign w_exit   = (r_state == S_SAMPLE) && (w_zero || w_hit || w_last);
  assign w_unused = ^rnd_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req) w_next = S_SAMPLE;
      S_SAMPLE: if (w_exit) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bound <= '0;
      r_mask  <= '0;
      r_noise <= '0;
      r_tries <= '0;
      r_err   <= 1'b0;
      r_index <= '0;
      r_walk  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && req) begin
        r_bound <= bound;
        r_mask  <= w_mask;
        r_noise <= noise;
        r_tries <= '0;
        r_err   <= 1'b0;
      end
      if (r_state == S_SAMPLE) begin
        if (w_zero) begin
          r_index <= '0;
          r_walk  <= 1'b0;
          r_err   <= 1'b1;
        end else if (w_hit) begin
          r_index <= w_cand;
          r_walk  <= w_walk;
        end else if (w_last) begin
          // cand < 2*bound, so one subtraction lands inside [0, bound)
          r_index <= w_cand - r_bound;
          r_walk  <= w_walk;
        end else begin
          r_tries <= r_tries + c_TRY_W'(1);
        end
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign valid = (r_state == S_DONE);
  assign err   = valid && r_err;
  assign index = r_index;
  assign walk  = r_walk;

endmodule

`default_nettype wire

// File: tb/tb_random_pick.sv
// ============================================================================
// Module   : tb_random_pick
// Purpose  : Self-checking bench for random_pick against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_random_pick;

  localparam int WIDTH     = 32;
  localparam int IDX_W     = 8;
  localparam int P_W       = 8;
  localparam int MAX_TRIES = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] rnd_in;
  logic             req;
  logic [IDX_W-1:0] bound;
  logic [P_W-1:0]   noise;
  logic             busy;
  logic             valid;
  logic [IDX_W-1:0] index;
  logic             walk;
  logic             err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] words [32];

  random_pick #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .P_W(P_W), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .reset(reset), .rnd_in(rnd_in), .req(req), .bound(bound),
    .noise(noise), .busy(busy), .valid(valid), .index(index), .walk(walk),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: mask is the next power of two at or above bound, minus one.
  task automatic model(input int b, input int nz, output int k, output int idx,
                       output bit wk, output bit er);
    int m;
    int c;
    k = 0; idx = 0; wk = 0; er = 0;
    if (b == 0) begin
      er = 1;
      return;
    end
    m = (b <= 1) ? 0 : ((1 << $clog2(b)) - 1);
    for (int t = 0; t < MAX_TRIES; t++) begin
      c = int'(words[t][7:0]) & m;
      k = t;
      if (c < b) begin
        idx = c;
        break;
      end
      if (t == MAX_TRIES - 1) idx = c - b;
    end
    wk = (int'(words[k][31:24]) < nz);
  endtask

  // One pick: words[] supplies rnd_in on successive sample edges.
  task automatic pick(input int b, input int nz, input bit req_noise,
                      output int oi, output bit ow);
    int  k, idx;
    bit  wk, er;
    logic [IDX_W-1:0] prev;
    model(b, nz, k, idx, wk, er);
    @(negedge clk);
    bound  = IDX_W'(b);
    noise  = P_W'(nz);
    req    = 1'b1;
    rnd_in = $urandom;
    @(negedge clk);
    req    = 1'b0;
    bound  = IDX_W'($urandom);
    noise  = P_W'($urandom);
    chk("busy_after_req", busy, 1);
    prev   = index;
    rnd_in = words[0];
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      if (i < k) begin
        chk("valid_low_sampling", valid, 0);
        chk("index_stable_busy", index, prev);
        rnd_in = words[i+1];
        if (req_noise) req = 1'($urandom_range(0, 1));
      end else begin
        chk("valid_pulse", valid, 1);
        chk("busy_in_done", busy, 1);
        chk("index", index, idx);
        chk("walk", walk, wk);
        chk("err", err, er);
        req = 1'b0;
      end
    end
    oi = int'(index);
    ow = walk;
    @(negedge clk);
    chk("valid_one_cycle", valid, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int  oi;
    bit  ow;
    int  hist [6];
    int  deck [6];
    int  walks, bad, nrej, j, tmp, flag;

    reset = 1'b0; req = 1'b0; bound = '0; noise = '0; rnd_in = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_index", index, 0);
    chk("rst_walk", walk, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Immediate accept
    for (int i = 0; i < 32; i++) words[i] = 32'h4000_0003;
    pick(10, 8'h80, 0, oi, ow);

    // Reset in the middle of sampling
    @(negedge clk);
    bound = 8'd5; noise = 8'hFF; rnd_in = 32'h0000_0007; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_index", index, 0);
    chk("midrst_walk", walk, 0);
    @(negedge clk);
    reset = 1'b1;
    flag = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid || busy) flag = 1;
    end
    chk("no_valid_after_reset", flag, 0);

    // Rejection, rejection, accept
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    words[0][7:0] = 8'h07; words[1][7:0] = 8'h06; words[2][7:0] = 8'h02;
    pick(5, 8'h40, 0, oi, ow);

    // Fallback after MAX_TRIES rejections
    for (int i = 0; i < 32; i++) words[i] = {$urandom_range(0, 255) << 24} | 32'h07;
    pick(5, 8'h80, 0, oi, ow);

    // bound = 1, bound = 0, bound = 255 with noise 0
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    pick(1, 8'hFF, 0, oi, ow);
    pick(0, 8'hFF, 0, oi, ow);
    words[0] = 32'hFFFF_FFFE;
    pick(255, 0, 0, oi, ow);
    words[0] = 32'hFFFF_FF00;
    pick(200, 8'hFF, 0, oi, ow);

    // Random bounds and noise
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      pick($urandom_range(0, 255), $urandom_range(0, 255), 1, oi, ow);
    end

    // Statistics with bound 6, noise 64; deck keeps first accepted values balanced
    for (int i = 0; i < 6; i++) hist[i] = 0;
    walks = 0; bad = 0;
    for (int p = 0; p < 12000; p++) begin
      if (p % 6 == 0) begin
        for (int i = 0; i < 6; i++) deck[i] = i;
        for (int i = 5; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = deck[i]; deck[i] = deck[j]; deck[j] = tmp;
        end
      end
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      nrej = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < nrej; i++) words[i][2:0] = 3'(6 + $urandom_range(0, 1));
      words[nrej][2:0] = 3'(deck[p % 6]);
      pick(6, 64, 1, oi, ow);
      if (oi < 6) hist[oi]++;
      else bad++;
      if (ow) walks++;
    end
    chk("stat_range", bad, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stat_hist%0d", i), (hist[i] >= 1900 && hist[i] <= 2100), 1);
    end
    chk("stat_walk_rate", (walks >= 2760 && walks <= 3240), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
